// File: rtl/kl10_cram_pkg.sv
// Shared CRAM geometry and the loader state encoding used by the CRAM front-end loader.
package kl10_cram_pkg;

   localparam int CRAM_ADDR_W  = 12;
   localparam int CRAM_WORD_W  = 84;
   localparam int CRAM_CHUNK_W = 12;
   localparam int CRAM_NCHUNK  = 7;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WR,
      ST_RADR,
      ST_RWAIT,
      ST_DONE
   } crm_ld_state_t;

endpackage

// File: rtl/crm_loader_if.sv
// Diag-side and RAM-side signals of the CRAM loader. The slave modport is the loader's own view;
// the master modport is the environment (front end, CPU and the RAM itself).
interface crm_loader_if;
   import kl10_cram_pkg::*;

   logic                    CPU_RUN;
   logic [CRAM_ADDR_W-1:0]  CPU_CRADR;
   logic                    CPU_GRANT;
   logic                    LD_ADR_WE;
   logic                    LD_CHUNK_WE;
   logic [2:0]              LD_SEL;
   logic [CRAM_CHUNK_W-1:0] LD_DATA;
   logic                    LD_AUTOINC;
   logic                    LD_WRITE;
   logic                    LD_READ;
   logic [CRAM_ADDR_W-1:0]  LD_ADR;
   logic [0:CRAM_WORD_W-1]  RB_DATA;
   logic                    LD_BUSY;
   logic                    LD_DONE;
   logic                    LD_ERR;
   logic [CRAM_ADDR_W-1:0]  MEM_ADDR;
   logic [0:CRAM_WORD_W-1]  MEM_DIN;
   logic                    MEM_WE;
   logic [0:CRAM_WORD_W-1]  MEM_DOUT;

   modport slave (
      input  CPU_RUN, CPU_CRADR, LD_ADR_WE, LD_CHUNK_WE, LD_SEL, LD_DATA,
             LD_AUTOINC, LD_WRITE, LD_READ, MEM_DOUT,
      output CPU_GRANT, LD_ADR, RB_DATA, LD_BUSY, LD_DONE, LD_ERR,
             MEM_ADDR, MEM_DIN, MEM_WE
   );

   modport master (
      output CPU_RUN, CPU_CRADR, LD_ADR_WE, LD_CHUNK_WE, LD_SEL, LD_DATA,
             LD_AUTOINC, LD_WRITE, LD_READ, MEM_DOUT,
      input  CPU_GRANT, LD_ADR, RB_DATA, LD_BUSY, LD_DONE, LD_ERR,
             MEM_ADDR, MEM_DIN, MEM_WE
   );

endinterface

// File: rtl/crm_loader.sv
// CRAM front-end loader: assembles 84-bit microwords from 12-bit diag chunks, writes/reads them
// through the single RAM port, and hands that port to the CPU whenever the loader is idle.
module crm_loader
   import kl10_cram_pkg::*;
#(
   parameter int RD_LAT = 1
) (
   input  logic        clk,
   input  logic        RESET,
   crm_loader_if.slave ld
);

   localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RD_LAT - 1);

   crm_ld_state_t           state_q;
   logic [CRAM_ADDR_W-1:0]  adr_q;
   logic [CRAM_CHUNK_W-1:0] stage_q [CRAM_NCHUNK];
   logic [0:CRAM_WORD_W-1]  rb_q;
   logic                    we_q;
   logic                    done_q;
   logic                    err_q;
   logic                    err_pend_q;
   logic [CNT_W-1:0]        cnt_q;

   logic                    idle;
   logic                    accept_wr;
   logic                    accept_rd;
   logic                    reject;
   logic                    done_d;
   logic [0:CRAM_WORD_W-1]  din;

   always_comb begin
      idle      = (state_q == ST_IDLE);
      accept_wr = idle && ld.LD_WRITE && !ld.LD_READ && !ld.CPU_RUN;
      accept_rd = idle && ld.LD_READ && !ld.LD_WRITE && !ld.CPU_RUN;
      reject    = (ld.LD_WRITE || ld.LD_READ) && !accept_wr && !accept_rd;
      done_d    = (state_q == ST_WR) || ((state_q == ST_RWAIT) && (cnt_q == '0));
   end

   always_comb begin
      din = '0;
      for (int k = 0; k < CRAM_NCHUNK; k++) begin
         din[k*CRAM_CHUNK_W +: CRAM_CHUNK_W] = stage_q[k];
      end
   end

   always_ff @(posedge clk or posedge RESET) begin
      if (RESET) begin
         state_q    <= ST_IDLE;
         adr_q      <= '0;
         rb_q       <= '0;
         we_q       <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         err_pend_q <= 1'b0;
         cnt_q      <= '0;
         for (int k = 0; k < CRAM_NCHUNK; k++) begin
            stage_q[k] <= '0;
         end
      end else begin
         we_q       <= 1'b0;
         done_q     <= done_d;
         // A rejection landing on the DONE cycle is deferred one cycle so DONE and ERR never overlap.
         err_q      <= (reject && !done_d) || err_pend_q;
         err_pend_q <= reject && done_d;

         case (state_q)
            ST_IDLE: begin
               if (accept_wr) begin
                  state_q <= ST_WR;
                  we_q    <= 1'b1;
               end else if (accept_rd) begin
                  state_q <= ST_RADR;
               end
            end
            ST_WR:   state_q <= ST_DONE;
            ST_RADR: begin
               state_q <= ST_RWAIT;
               cnt_q   <= CNT_LOAD;
            end
            ST_RWAIT: begin
               if (cnt_q == '0) begin
                  rb_q    <= ld.MEM_DOUT;
                  state_q <= ST_DONE;
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
            ST_DONE: state_q <= ST_IDLE;
            default: state_q <= ST_IDLE;
         endcase

         // Address and staging are frozen while the RAM is being written.
         if (state_q != ST_WR) begin
            if (ld.LD_ADR_WE) begin
               adr_q <= CRAM_ADDR_W'(ld.LD_DATA);
            end else if ((state_q == ST_DONE) && ld.LD_AUTOINC) begin
               adr_q <= adr_q + CRAM_ADDR_W'(1);
            end
            if (ld.LD_CHUNK_WE && (ld.LD_SEL < 3'(CRAM_NCHUNK))) begin
               stage_q[ld.LD_SEL] <= ld.LD_DATA;
            end
         end
      end
   end

   assign ld.CPU_GRANT = idle;
   assign ld.MEM_ADDR  = idle ? ld.CPU_CRADR : adr_q;
   assign ld.MEM_DIN   = din;
   assign ld.MEM_WE    = we_q;
   assign ld.LD_ADR    = adr_q;
   assign ld.RB_DATA   = rb_q;
   assign ld.LD_BUSY   = !idle;
   assign ld.LD_DONE   = done_q;
   assign ld.LD_ERR    = err_q;

endmodule

// File: tb/tb_crm_loader.sv
// Bench for crm_loader: directed and random loader traffic against a word-level reference model,
// with one instance at RD_LAT=1 and one at RD_LAT=3.
module tb_crm_loader;

   logic clk = 1'b0;
   logic rst1;
   logic rst3;
   always #5 clk = ~clk;

   crm_loader_if if1 ();
   crm_loader_if if3 ();

   crm_loader #(.RD_LAT(1)) u1 (.clk(clk), .RESET(rst1), .ld(if1));
   crm_loader #(.RD_LAT(3)) u3 (.clk(clk), .RESET(rst3), .ld(if3));

   // RAM models: ram1 written by u1 with 1-cycle read; ram3 preloaded, 3-cycle read.
   logic [0:83] ram1 [4096];
   logic [0:83] ram3 [4096];
   logic [11:0] a1_q;
   logic [11:0] a3_q [3];

   always @(posedge clk) begin
      if (if1.MEM_WE) ram1[if1.MEM_ADDR] <= if1.MEM_DIN;
      a1_q    <= if1.MEM_ADDR;
      a3_q[0] <= if3.MEM_ADDR;
      a3_q[1] <= a3_q[0];
      a3_q[2] <= a3_q[1];
   end
   assign if1.MEM_DOUT = ram1[a1_q];
   assign if3.MEM_DOUT = ram3[a3_q[2]];

   int n_assert = 0;
   int n_fail   = 0;
   int we1 = 0, done1 = 0, err1 = 0, done3 = 0;
   logic [11:0] we1_adr;

   // Reference model: staging chunks, address register, memory image, readback.
   logic [11:0] st [7];
   logic [11:0] exp_adr;
   logic [83:0] exp_rb;
   logic [83:0] exp_mem [logic [11:0]];
   bit          autoinc;

   function automatic logic [83:0] exp_word();
      return {st[0], st[1], st[2], st[3], st[4], st[5], st[6]};
   endfunction

   function automatic logic [83:0] pat(int a);
      return {7{12'(a)}} ^ 84'h0123456789ABCDEF01234;
   endfunction

   task automatic check(string tag, logic [83:0] obs, logic [83:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      if (if1.MEM_WE) begin
         we1++;
         we1_adr = if1.MEM_ADDR;
      end
      if (if1.LD_DONE) done1++;
      if (if1.LD_ERR) err1++;
      if (if3.LD_DONE) done3++;
      check("done_err_excl", 84'(if1.LD_DONE && if1.LD_ERR), 84'(0));
   endtask

   task automatic set_adr(logic [11:0] a);
      if1.LD_ADR_WE = 1'b1;
      if1.LD_DATA   = a;
      tick();
      if1.LD_ADR_WE = 1'b0;
      exp_adr = a;
   endtask

   task automatic set_chunk(int k, logic [11:0] d);
      if1.LD_CHUNK_WE = 1'b1;
      if1.LD_SEL      = 3'(k);
      if1.LD_DATA     = d;
      tick();
      if1.LD_CHUNK_WE = 1'b0;
      if (k < 7) st[k] = d;
   endtask

   task automatic do_write();
      logic [83:0] w;
      int base_we;
      w = exp_word();
      base_we = we1;
      if1.LD_AUTOINC = autoinc;
      if1.LD_WRITE = 1'b1;
      tick();
      if1.LD_WRITE = 1'b0;
      check("wr_we", 84'(if1.MEM_WE), 84'(1));
      check("wr_addr", 84'(if1.MEM_ADDR), 84'(exp_adr));
      check("wr_din", 84'(if1.MEM_DIN), w);
      check("wr_grant", 84'(if1.CPU_GRANT), 84'(0));
      tick();
      check("wr_done", 84'(if1.LD_DONE), 84'(1));
      exp_mem[exp_adr] = w;
      if (autoinc) exp_adr = exp_adr + 12'd1;
      tick();
      check("wr_adr_after", 84'(if1.LD_ADR), 84'(exp_adr));
      check("wr_idle", 84'(if1.LD_BUSY), 84'(0));
      check("wr_we_count", 84'(we1 - base_we), 84'(1));
   endtask

   task automatic do_read();
      if1.LD_AUTOINC = autoinc;
      if1.LD_READ = 1'b1;
      tick();
      if1.LD_READ = 1'b0;
      check("rd_radr_nodone", 84'(if1.LD_DONE), 84'(0));
      tick();
      check("rd_rwait_nodone", 84'(if1.LD_DONE), 84'(0));
      tick();
      check("rd_done", 84'(if1.LD_DONE), 84'(1));
      exp_rb = exp_mem.exists(exp_adr) ? exp_mem[exp_adr] : 84'(0);
      check("rd_data", 84'(if1.RB_DATA), exp_rb);
      if (autoinc) exp_adr = exp_adr + 12'd1;
      tick();
      check("rd_adr_after", 84'(if1.LD_ADR), 84'(exp_adr));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [11:0] addrs [6];
      int base_we, base_done;

      for (int a = 0; a < 4096; a++) ram3[a] = pat(a);
      for (int k = 0; k < 7; k++) st[k] = '0;
      exp_adr = '0; exp_rb = '0; autoinc = 1'b0;
      rst1 = 1'b1; rst3 = 1'b1;
      if1.CPU_RUN = 1'b1; if1.CPU_CRADR = 12'o1234;
      if1.LD_ADR_WE = 0; if1.LD_CHUNK_WE = 0; if1.LD_SEL = 0; if1.LD_DATA = 0;
      if1.LD_AUTOINC = 0; if1.LD_WRITE = 0; if1.LD_READ = 0;
      if3.CPU_RUN = 1'b0; if3.CPU_CRADR = 12'o0;
      if3.LD_ADR_WE = 0; if3.LD_CHUNK_WE = 0; if3.LD_SEL = 0; if3.LD_DATA = 0;
      if3.LD_AUTOINC = 0; if3.LD_WRITE = 0; if3.LD_READ = 0;
      tick(); tick();

      check("rst_mem_addr", 84'(if1.MEM_ADDR), 84'(12'o1234));
      check("rst_grant", 84'(if1.CPU_GRANT), 84'(1));
      check("rst_we", 84'(if1.MEM_WE), 84'(0));
      check("rst_done", 84'(if1.LD_DONE), 84'(0));
      check("rst_err", 84'(if1.LD_ERR), 84'(0));
      check("rst_adr", 84'(if1.LD_ADR), 84'(0));
      check("rst_rb", 84'(if1.RB_DATA), 84'(0));
      check("rst_din", 84'(if1.MEM_DIN), 84'(0));
      check("rst_busy", 84'(if1.LD_BUSY), 84'(0));
      rst1 = 1'b0; rst3 = 1'b0;
      tick();
      if1.CPU_CRADR = 12'o4321;
      tick();
      check("cpu_mux", 84'(if1.MEM_ADDR), 84'(12'o4321));
      if1.CPU_RUN = 1'b0;

      // Directed word at 0o0100, then readback.
      set_adr(12'o0100);
      for (int k = 0; k < 7; k++) set_chunk(k, 12'(k + 1));
      do_write();
      check("dir_ram", 84'(ram1[12'o0100]), exp_word());
      do_read();

      // Out-of-range chunk index leaves staging alone.
      set_chunk(7, 12'o7777);
      check("sel7_ignored", 84'(if1.MEM_DIN), exp_word());

      // Auto-increment wrap 0o7777 -> 0, second write lands at 0.
      autoinc = 1'b1;
      set_adr(12'o7777);
      for (int k = 0; k < 7; k++) set_chunk(k, 12'($urandom));
      do_write();
      check("wrap_adr", 84'(if1.LD_ADR), 84'(0));
      for (int k = 0; k < 7; k++) set_chunk(k, 12'($urandom));
      do_write();
      check("wrap_we_adr", 84'(we1_adr), 84'(0));
      check("wrap_ram0", 84'(ram1[0]), exp_mem[12'd0]);

      // Writes during WR are ignored; LD_ADR_WE beats auto-increment in DONE.
      set_adr(12'o0200);
      if1.LD_AUTOINC = 1'b1;
      if1.LD_WRITE = 1'b1;
      tick();
      if1.LD_WRITE = 1'b0;
      if1.LD_CHUNK_WE = 1'b1; if1.LD_SEL = 3'd0; if1.LD_ADR_WE = 1'b1; if1.LD_DATA = 12'o5555;
      tick();
      if1.LD_CHUNK_WE = 1'b0;
      check("prec_done", 84'(if1.LD_DONE), 84'(1));
      check("wr_chunk_ignored", 84'(if1.MEM_DIN), exp_word());
      check("wr_adrwe_ignored", 84'(if1.LD_ADR), 84'(12'o0200));
      exp_mem[12'o0200] = exp_word();
      if1.LD_DATA = 12'o3333;
      tick();
      if1.LD_ADR_WE = 1'b0;
      exp_adr = 12'o3333;
      check("prec_adr", 84'(if1.LD_ADR), 84'(12'o3333));
      autoinc = 1'b0;
      if1.LD_AUTOINC = 1'b0;

      // Rejected commands.
      set_adr(12'o0100);
      base_we = we1;
      if1.CPU_RUN = 1'b1; if1.LD_WRITE = 1'b1;
      tick();
      if1.LD_WRITE = 1'b0; if1.CPU_RUN = 1'b0;
      check("cpurun_err", 84'(if1.LD_ERR), 84'(1));
      check("cpurun_grant", 84'(if1.CPU_GRANT), 84'(1));
      tick();
      check("cpurun_err_pulse", 84'(if1.LD_ERR), 84'(0));
      if1.LD_WRITE = 1'b1; if1.LD_READ = 1'b1;
      tick();
      if1.LD_WRITE = 1'b0; if1.LD_READ = 1'b0;
      check("both_err", 84'(if1.LD_ERR), 84'(1));
      check("both_busy", 84'(if1.LD_BUSY), 84'(0));
      tick();
      check("rej_no_we", 84'(we1 - base_we), 84'(0));
      check("rej_adr", 84'(if1.LD_ADR), 84'(exp_adr));
      check("rej_rb", 84'(if1.RB_DATA), exp_rb);

      // Read issued again while the first read is in flight.
      base_done = done1;
      if1.LD_READ = 1'b1;
      tick();
      tick();
      if1.LD_READ = 1'b0;
      check("busy_err", 84'(if1.LD_ERR), 84'(1));
      tick();
      check("busy_op_done", 84'(if1.LD_DONE), 84'(1));
      exp_rb = exp_mem[exp_adr];
      check("busy_op_data", 84'(if1.RB_DATA), exp_rb);
      tick(); tick();
      check("busy_one_done", 84'(done1 - base_done), 84'(1));
      check("busy_idle", 84'(if1.LD_BUSY), 84'(0));

      // Random words at random addresses, read back in reverse order.
      for (int i = 0; i < 6; i++) begin
         addrs[i] = 12'($urandom_range(0, 4095));
         set_adr(addrs[i]);
         for (int k = 0; k < 7; k++) set_chunk(k, 12'($urandom));
         do_write();
      end
      for (int i = 5; i >= 0; i--) begin
         set_adr(addrs[i]);
         do_read();
      end

      // Reset in the middle of a write drops MEM_WE immediately.
      set_adr(12'o0055);
      if1.LD_WRITE = 1'b1;
      tick();
      if1.LD_WRITE = 1'b0;
      check("midwr_we", 84'(if1.MEM_WE), 84'(1));
      base_done = done1;
      #2 rst1 = 1'b1;
      #1;
      check("midwr_rst_we", 84'(if1.MEM_WE), 84'(0));
      check("midwr_rst_busy", 84'(if1.LD_BUSY), 84'(0));
      check("midwr_rst_adr", 84'(if1.LD_ADR), 84'(0));
      check("midwr_rst_din", 84'(if1.MEM_DIN), 84'(0));
      tick();
      rst1 = 1'b0;
      tick(); tick(); tick();
      check("midwr_no_done", 84'(done1 - base_done), 84'(0));

      // RD_LAT=3 instance: full read latency, then reset during RWAIT.
      if3.LD_ADR_WE = 1'b1; if3.LD_DATA = 12'd5;
      tick();
      if3.LD_ADR_WE = 1'b0;
      if3.LD_READ = 1'b1;
      tick();
      if3.LD_READ = 1'b0;
      for (int c = 0; c < 3; c++) begin
         tick();
         check("lat3_nodone", 84'(if3.LD_DONE), 84'(0));
      end
      tick();
      check("lat3_done", 84'(if3.LD_DONE), 84'(1));
      check("lat3_data", 84'(if3.RB_DATA), pat(5));
      tick();
      if3.LD_ADR_WE = 1'b1; if3.LD_DATA = 12'd9;
      tick();
      if3.LD_ADR_WE = 1'b0;
      if3.LD_READ = 1'b1;
      tick();
      if3.LD_READ = 1'b0;
      tick();
      check("lat3_in_rwait", 84'(if3.LD_BUSY), 84'(1));
      base_done = done3;
      #2 rst3 = 1'b1;
      #1;
      check("rwait_rst_busy", 84'(if3.LD_BUSY), 84'(0));
      check("rwait_rst_grant", 84'(if3.CPU_GRANT), 84'(1));
      check("rwait_rst_rb", 84'(if3.RB_DATA), 84'(0));
      check("rwait_rst_adr", 84'(if3.LD_ADR), 84'(0));
      tick(); tick();
      rst3 = 1'b0;
      for (int c = 0; c < 5; c++) tick();
      check("rwait_no_done", 84'(done3 - base_done), 84'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
